// File: rtl/aes_wrapper_pkg.sv
// Shared constants for the streaming AES wrapper: register map,
// CTRL/STATUS bit positions and sequencer state encoding.
package aes_wrapper_pkg;

    // Word addresses
    localparam int ADDR_CTRL   = 0;
    localparam int ADDR_STATUS = 1;
    localparam int ADDR_DIN    = 2;
    localparam int ADDR_DOUT   = 3;
    localparam int ADDR_LEVEL  = 4;

    // CTRL bits
    localparam int CTRL_EN    = 0;
    localparam int CTRL_IRQEN = 1;
    localparam int CTRL_CLR   = 2;

    // STATUS bits
    localparam int STAT_INFULL   = 0;
    localparam int STAT_INEMPTY  = 1;
    localparam int STAT_OUTFULL  = 2;
    localparam int STAT_OUTEMPTY = 3;
    localparam int STAT_BUSY     = 4;
    localparam int STAT_OVF      = 5;
    localparam int STAT_UDF      = 6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_FLUSH = 2'd3
    } seqState_t;

endpackage

// File: rtl/aes_stream_wrapper_if.sv
// Avalon-MM slave bus bundle (plus level IRQ) for the streaming AES wrapper.
interface aes_stream_wrapper_if #(
    parameter int BUS_W  = 32,
    parameter int ADDR_W = 8
) ();
    logic              iChipselect;
    logic              iWrite;
    logic              iRead;
    logic [ADDR_W-1:0] iAddress;
    logic [BUS_W-1:0]  iWrite_data;
    logic [BUS_W-1:0]  oRead_data;
    logic              oIrq;

    modport slave (
        input  iChipselect, iWrite, iRead, iAddress, iWrite_data,
        output oRead_data, oIrq
    );

    modport master (
        output iChipselect, iWrite, iRead, iAddress, iWrite_data,
        input  oRead_data, oIrq
    );
endinterface

// File: rtl/aes_block_fifo.sv
// Synchronous block FIFO with combinational head, simultaneous push/pop
// and a synchronous clear that overrides push and pop.
module aes_block_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rstN,
    input  logic                   clr,
    input  logic                   push,
    input  logic [WIDTH-1:0]       pushData,
    input  logic                   pop,
    output logic [WIDTH-1:0]       headData,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr, rdPtr;
    logic             doPush, doPop;

    assign full     = (level == ($clog2(DEPTH)+1)'(DEPTH));
    assign empty    = (level == '0);
    assign headData = mem[rdPtr];
    // A push into a full FIFO is accepted only when a pop frees the slot
    assign doPush   = push & (~full | pop);
    assign doPop    = pop & ~empty;

    // Pointer and level bookkeeping; pointers wrap naturally (DEPTH is 2^n)
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else if (clr) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PTR_W'(1);
            if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
            if (doPush && !doPop)      level <= level + 1'b1;
            else if (doPop && !doPush) level <= level - 1'b1;
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (doPush && !clr) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/aes_stream_wrapper.sv
// Avalon-MM streaming front end for a block cipher core: assembles bus
// words into blocks, sequences blocks through the core, and returns
// results word by word from an output FIFO.
module aes_stream_wrapper
    import aes_wrapper_pkg::*;
#(
    parameter int BUS_W      = 32,
    parameter int BLOCK_W    = 128,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 8
) (
    input  logic                 iClk,
    input  logic                 iReset_n,
    aes_stream_wrapper_if.slave  bus,
    output logic                 oCore_start,
    output logic [BLOCK_W-1:0]   oCore_block,
    input  logic                 iCore_ready,
    input  logic                 iCore_valid,
    input  logic [BLOCK_W-1:0]   iCore_result
);
    localparam int WPB   = BLOCK_W / BUS_W;
    localparam int CNT_W = (WPB > 1) ? $clog2(WPB) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    // Bus decode
    logic rdEn, wrEn, clr;
    logic isCtrl, isStatus, isDin, isDout, isLevel;
    assign rdEn     = bus.iChipselect & bus.iRead;
    assign wrEn     = bus.iChipselect & bus.iWrite & ~bus.iRead;
    assign isCtrl   = (bus.iAddress == ADDR_W'(ADDR_CTRL));
    assign isStatus = (bus.iAddress == ADDR_W'(ADDR_STATUS));
    assign isDin    = (bus.iAddress == ADDR_W'(ADDR_DIN));
    assign isDout   = (bus.iAddress == ADDR_W'(ADDR_DOUT));
    assign isLevel  = (bus.iAddress == ADDR_W'(ADDR_LEVEL));
    assign clr      = wrEn & isCtrl & bus.iWrite_data[CTRL_CLR];

    logic enable, irqEn, ovf, udf, irqReg;
    logic [BUS_W-1:0] rdData, rdMux;

    // FIFO wiring
    logic               inPush, inPop, inFull, inEmpty;
    logic               outPush, outPop, outFull, outEmpty;
    logic [BLOCK_W-1:0] inHead, outHead, inAsmNext;
    logic [LVL_W-1:0]   inLevel, outLevel;

    // Word assembly: MS word first, so each new word shifts in at the bottom
    logic [BLOCK_W-1:0] inAsm;
    logic [CNT_W-1:0]   inCnt, outCnt;
    logic               dinWr, inLast, doutRd, outLast;
    assign dinWr     = wrEn & isDin;
    assign inLast    = (inCnt == CNT_W'(WPB-1));
    assign inAsmNext = (inAsm << BUS_W) | BLOCK_W'(bus.iWrite_data);
    assign inPush    = dinWr & inLast & ~inFull;

    // Word disassembly: outCnt selects the word of the head block, MS first
    logic [BUS_W-1:0] outWord;
    assign doutRd  = rdEn & isDout;
    assign outLast = (outCnt == CNT_W'(WPB-1));
    assign outWord = BUS_W'(outHead >> ((WPB - 1 - int'(outCnt)) * BUS_W));
    assign outPop  = doutRd & ~outEmpty & outLast;

    aes_block_fifo #(.WIDTH(BLOCK_W), .DEPTH(FIFO_DEPTH)) uInFifo (
        .clk(iClk), .rstN(iReset_n), .clr(clr),
        .push(inPush), .pushData(inAsmNext), .pop(inPop),
        .headData(inHead), .full(inFull), .empty(inEmpty), .level(inLevel)
    );

    aes_block_fifo #(.WIDTH(BLOCK_W), .DEPTH(FIFO_DEPTH)) uOutFifo (
        .clk(iClk), .rstN(iReset_n), .clr(clr),
        .push(outPush), .pushData(iCore_result), .pop(outPop),
        .headData(outHead), .full(outFull), .empty(outEmpty), .level(outLevel)
    );

    // Assembly/disassembly counters; a completed block always wraps the counter
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            inAsm  <= '0;
            inCnt  <= '0;
            outCnt <= '0;
        end else if (clr) begin
            inAsm  <= '0;
            inCnt  <= '0;
            outCnt <= '0;
        end else begin
            if (dinWr) begin
                inAsm <= inAsmNext;
                inCnt <= inLast ? '0 : inCnt + CNT_W'(1);
            end
            if (doutRd && !outEmpty)
                outCnt <= outLast ? '0 : outCnt + CNT_W'(1);
        end
    end

    // CTRL register and sticky overflow/underflow flags (write-1-to-clear)
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            enable <= 1'b0;
            irqEn  <= 1'b0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            if (wrEn && isCtrl) begin
                enable <= bus.iWrite_data[CTRL_EN];
                irqEn  <= bus.iWrite_data[CTRL_IRQEN];
            end
            if (dinWr && inLast && inFull)                      ovf <= 1'b1;
            else if (wrEn && isStatus && bus.iWrite_data[STAT_OVF]) ovf <= 1'b0;
            if (doutRd && outEmpty)                             udf <= 1'b1;
            else if (wrEn && isStatus && bus.iWrite_data[STAT_UDF]) udf <= 1'b0;
        end
    end

    // Sequencer
    seqState_t state, nextState;
    logic      latchBlock;

    // Sequencer state register and the block held toward the core
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state       <= S_IDLE;
            oCore_block <= '0;
        end else begin
            state <= nextState;
            if (latchBlock) oCore_block <= inHead;
        end
    end

    // Sequencer next state and FIFO strobes
    always_comb begin
        nextState  = state;
        latchBlock = 1'b0;
        inPop      = 1'b0;
        outPush    = 1'b0;
        unique case (state)
            S_IDLE: begin
                // Nothing is in flight in IDLE, so the slot reservation
                // reduces to a free entry in the output FIFO.
                if (enable && !inEmpty && iCore_ready && !outFull && !clr) begin
                    nextState  = S_START;
                    latchBlock = 1'b1;
                end
            end
            S_START: begin
                inPop     = 1'b1;
                nextState = clr ? S_FLUSH : S_WAIT;
            end
            S_WAIT: begin
                if (iCore_valid) begin
                    outPush   = ~clr;
                    nextState = S_IDLE;
                end else if (clr) begin
                    nextState = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (iCore_valid) nextState = S_IDLE;
            end
            default: nextState = S_IDLE;
        endcase
    end

    assign oCore_start = (state == S_START);

    // Read mux for the addressed register
    always_comb begin
        rdMux = '0;
        if (isCtrl) begin
            rdMux[CTRL_EN]    = enable;
            rdMux[CTRL_IRQEN] = irqEn;
        end else if (isStatus) begin
            rdMux[STAT_INFULL]   = inFull;
            rdMux[STAT_INEMPTY]  = inEmpty;
            rdMux[STAT_OUTFULL]  = outFull;
            rdMux[STAT_OUTEMPTY] = outEmpty;
            rdMux[STAT_BUSY]     = (state != S_IDLE);
            rdMux[STAT_OVF]      = ovf;
            rdMux[STAT_UDF]      = udf;
        end else if (isDout) begin
            rdMux = outEmpty ? '0 : outWord;
        end else if (isLevel) begin
            rdMux[7:0]  = 8'(inLevel);
            rdMux[15:8] = 8'(outLevel);
        end
    end

    // Registered read data (latency 1, zero when idle) and level IRQ
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            rdData <= '0;
            irqReg <= 1'b0;
        end else begin
            rdData <= rdEn ? rdMux : '0;
            irqReg <= irqEn & (~outEmpty | ovf | udf);
        end
    end

    assign bus.oRead_data = rdData;
    assign bus.oIrq       = irqReg;

endmodule
